// File: rtl/hdr_cmd_sequencer.sv
// HDR command sequencer: descriptor FIFO in front of an issue FSM that holds the
// engine config for a setup window, then enables the engine and chains restart segments.
//
// state  | meaning
// IDLE   | waiting for an issuable descriptor at the FIFO head
// SETUP  | config presented, enable held low for SETUP_CYC cycles
// RUN    | engine enabled; lookahead config shown while current TOC=0
// FLUSH  | after a timeout, drop queued entries up to and including a TOC=1
module hdr_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  input  logic                     i_push_valid,
  output logic                     o_push_ready,
  input  logic                     i_push_cp,
  input  logic                     i_push_toc,
  input  logic [2:0]               i_push_mode,
  input  logic [3:0]               i_push_tid,
  input  logic                     i_seg_done,
  input  logic                     i_hdr_done,
  output logic                     o_hdr_en,
  output logic                     o_cp,
  output logic                     o_toc,
  output logic [2:0]               o_mode,
  output logic [3:0]               o_tid,
  output logic                     o_cmd_done,
  output logic                     o_cmd_err,
  output logic [3:0]               o_cmd_tid,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic       cp;
    logic       toc;
    logic [2:0] mode;
    logic [3:0] tid;
  } desc_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_FLUSH} state_t;

  desc_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  desc_t           push_desc, head, head_nxt, cur_q, cur_nxt, cfg_nxt;
  logic            push, pop, cfg_load;
  state_t          state_q;
  logic [SW-1:0]   setup_cnt_q;
  logic [TW-1:0]   tmo_cnt_q;

  assign o_push_ready = (level_q != LW'(DEPTH));
  assign push         = i_push_valid & o_push_ready;
  assign push_desc    = {i_push_cp, i_push_toc, i_push_mode, i_push_tid};
  assign head         = mem_q[rd_ptr_q];
  assign rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign o_fifo_level = level_q;
  assign o_busy       = (state_q != ST_IDLE);

  // Head after this edge: a write landing at the new read pointer is the new head.
  assign head_nxt = (push && (wr_ptr_q == rd_ptr_d)) ? push_desc : mem_q[rd_ptr_d];
  assign cur_nxt  = (state_q == ST_RUN && pop) ? head : cur_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = (level_q != '0) && (head.toc || (level_q >= LW'(2)));
      ST_RUN:   pop = !cur_q.toc && i_seg_done && (level_q != '0);
      ST_FLUSH: pop = (level_q != '0);
      default:  pop = 1'b0;
    endcase
  end

  // A restart segment shows its successor; hold the last shown config if none is queued.
  always_comb begin
    cfg_nxt  = cur_nxt;
    cfg_load = 1'b1;
    if (!cur_nxt.toc) begin
      cfg_nxt  = head_nxt;
      cfg_load = (level_d != '0);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_desc;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      o_hdr_en    <= 1'b0;
      o_cmd_done  <= 1'b0;
      o_cmd_err   <= 1'b0;
      o_cp        <= 1'b0;
      o_toc       <= 1'b1;
      o_mode      <= 3'd6;
      o_tid       <= '0;
      o_cmd_tid   <= '0;
    end else begin
      o_cmd_done <= 1'b0;
      o_cmd_err  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            cur_q       <= head;
            o_cp        <= head.cp;
            o_toc       <= head.toc;
            o_mode      <= head.mode;
            o_tid       <= head.tid;
            setup_cnt_q <= SETUP_LOAD;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (setup_cnt_q == '0) begin
            o_hdr_en  <= 1'b1;
            tmo_cnt_q <= TMO_LOAD;
            state_q   <= ST_RUN;
            if (cfg_load) begin
              o_cp   <= cfg_nxt.cp;
              o_toc  <= cfg_nxt.toc;
              o_mode <= cfg_nxt.mode;
            end
          end else begin
            setup_cnt_q <= setup_cnt_q - SW'(1);
          end
        end
        ST_RUN: begin
          if (cur_q.toc && i_hdr_done) begin
            o_hdr_en   <= 1'b0;
            o_cmd_done <= 1'b1;
            o_cmd_tid  <= cur_q.tid;
            state_q    <= ST_IDLE;
          end else if (i_seg_done || (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= i_seg_done ? TMO_LOAD : tmo_cnt_q - TW'(1);
            if (pop) begin
              cur_q <= head;
              o_tid <= head.tid;
            end
            if (cfg_load) begin
              o_cp   <= cfg_nxt.cp;
              o_toc  <= cfg_nxt.toc;
              o_mode <= cfg_nxt.mode;
            end
          end else begin
            o_hdr_en  <= 1'b0;
            o_cmd_err <= 1'b1;
            o_cmd_tid <= cur_q.tid;
            state_q   <= cur_q.toc ? ST_IDLE : ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (pop && head.toc) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_cmd_sequencer.sv
// Bench for hdr_cmd_sequencer: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hdr_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int SETUP_CYC = 2;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst, push_valid, push_ready, push_cp, push_toc;
  logic [2:0] push_mode;
  logic [3:0] push_tid;
  logic       seg_done, hdr_done, hdr_en, cp, toc, cmd_done, cmd_err, busy;
  logic [2:0] mode;
  logic [3:0] tid, cmd_tid;
  logic [2:0] level;

  always #5 clk = ~clk;

  hdr_cmd_sequencer #(.DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TMO)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_push_valid(push_valid), .o_push_ready(push_ready),
    .i_push_cp(push_cp), .i_push_toc(push_toc), .i_push_mode(push_mode), .i_push_tid(push_tid),
    .i_seg_done(seg_done), .i_hdr_done(hdr_done),
    .o_hdr_en(hdr_en), .o_cp(cp), .o_toc(toc), .o_mode(mode), .o_tid(tid),
    .o_cmd_done(cmd_done), .o_cmd_err(cmd_err), .o_cmd_tid(cmd_tid),
    .o_busy(busy), .o_fifo_level(level)
  );

  typedef struct packed {
    logic       cp;
    logic       toc;
    logic [2:0] mode;
    logic [3:0] tid;
  } d_t;

  int checks = 0;
  int failures = 0;

  // reference model: phase 0 idle, 1 setup, 2 run, 3 flush
  d_t   mq[$];
  d_t   m_cur, m_cfg;
  int   m_ph, m_setup_left, m_run_cnt;
  bit   m_en, m_done, m_err;
  logic [3:0] m_tid, m_ctid;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_en = 0; m_done = 0; m_err = 0;
    m_tid = 0; m_ctid = 0; m_cur = '0;
    m_cfg = {1'b0, 1'b1, 3'd6, 4'd0};
    m_setup_left = 0; m_run_cnt = 0;
  endtask

  task automatic model_step();
    d_t nd, dd;
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    nd = {push_cp, push_toc, push_mode, push_tid};
    acc = push_valid && (mq.size() < DEPTH);
    m_done = 0; m_err = 0;
    case (m_ph)
      0: if (mq.size() >= 1 && (mq[0].toc || mq.size() >= 2)) begin
           m_cur = mq.pop_front();
           m_cfg = m_cur; m_tid = m_cur.tid;
           m_setup_left = SETUP_CYC; m_ph = 1;
         end
      1: begin
           m_setup_left--;
           if (m_setup_left == 0) begin m_ph = 2; m_en = 1; m_run_cnt = 0; end
         end
      2: if (m_cur.toc && hdr_done) begin
           m_en = 0; m_done = 1; m_ctid = m_cur.tid; m_ph = 0;
         end else if (seg_done) begin
           m_run_cnt = 0;
           if (!m_cur.toc && mq.size() > 0) begin
             m_cur = mq.pop_front(); m_tid = m_cur.tid;
           end
         end else begin
           m_run_cnt++;
           if (m_run_cnt == TMO) begin
             m_en = 0; m_err = 1; m_ctid = m_cur.tid;
             m_ph = m_cur.toc ? 0 : 3;
           end
         end
      3: if (mq.size() > 0) begin
           dd = mq.pop_front();
           if (dd.toc) m_ph = 0;
         end
      default: m_ph = 0;
    endcase
    if (acc) mq.push_back(nd);
    if (m_ph == 2) begin
      if (m_cur.toc) m_cfg = m_cur;
      else if (mq.size() > 0) m_cfg = mq[0];
    end
  endtask

  task automatic compare();
    chk("hdr_en", int'(hdr_en), int'(m_en));
    chk("cmd_done", int'(cmd_done), int'(m_done));
    chk("cmd_err", int'(cmd_err), int'(m_err));
    chk("cmd_tid", int'(cmd_tid), int'(m_ctid));
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("fifo_level", int'(level), mq.size());
    chk("push_ready", int'(push_ready), int'(mq.size() != DEPTH));
    chk("cfg", int'({cp, toc, mode}), int'({m_cfg.cp, m_cfg.toc, m_cfg.mode}));
    chk("tid", int'(tid), int'(m_tid));
    chk("done_err_excl", int'(cmd_done & cmd_err), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic push(input bit c, input bit t, input int md, input int id);
    push_valid = 1; push_cp = c; push_toc = t; push_mode = 3'(md); push_tid = 4'(id);
    tick();
    push_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; seg_done = 0; hdr_done = 0; push_valid = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (!hdr_en && n < 40) begin tick(); n++; end
    chk({nm, "_wait_en"}, int'(hdr_en), 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    seg_done = 1; hdr_done = 1;
    while ((busy || level != 0) && n < 400) begin tick(); n++; end
    seg_done = 0; hdr_done = 0;
    chk({nm, "_drained"}, int'(busy || level != 0), 0);
  endtask

  initial begin
    rst = 1; push_valid = 0; push_cp = 0; push_toc = 0; push_mode = 0; push_tid = 0;
    seg_done = 0; hdr_done = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    chk("rst_toc", int'(toc), 1);
    chk("rst_mode", int'(mode), 6);
    chk("rst_level", int'(level), 0);
    chk("rst_en", int'(hdr_en), 0);

    // single CCC exit
    push(1, 1, 6, 3);
    tick(); tick();
    chk("t1_en_before", int'(hdr_en), 0);
    tick();
    chk("t1_en_rise", int'(hdr_en), 1);
    chk("t1_cp", int'(cp), 1);
    hdr_done = 1; tick(); hdr_done = 0;
    chk("t1_done", int'(cmd_done), 1);
    chk("t1_cmd_tid", int'(cmd_tid), 3);
    chk("t1_en_fall", int'(hdr_en), 0);
    chk("t1_busy", int'(busy), 0);
    tick();
    chk("t1_done_pulse", int'(cmd_done), 0);

    // restart chain
    do_reset();
    push(1, 0, 6, 5);
    push(0, 1, 6, 6);
    wait_en("t2");
    chk("t2_look_cp", int'(cp), 0);
    chk("t2_look_toc", int'(toc), 1);
    chk("t2_tid", int'(tid), 5);
    seg_done = 1; tick(); seg_done = 0;
    chk("t2_tid_next", int'(tid), 6);
    chk("t2_en_held", int'(hdr_en), 1);
    hdr_done = 1; tick(); hdr_done = 0;
    chk("t2_done", int'(cmd_done), 1);
    chk("t2_cmd_tid", int'(cmd_tid), 6);

    // lookahead guard
    do_reset();
    push(0, 0, 6, 1);
    repeat (5) tick();
    chk("t3_idle", int'(busy), 0);
    chk("t3_en", int'(hdr_en), 0);
    push(1, 1, 6, 2);
    wait_en("t3");
    chk("t3_tid", int'(tid), 1);
    drain("t3");

    // FIFO full while a command runs
    do_reset();
    push(0, 1, 6, 7);
    wait_en("t4");
    for (int i = 0; i < 4; i++) push(0, 1, 6, 8 + i);
    chk("t4_level_full", int'(level), 4);
    chk("t4_ready_low", int'(push_ready), 0);
    push(0, 1, 6, 12);
    chk("t4_level_refused", int'(level), 4);
    hdr_done = 1; tick(); hdr_done = 0;
    tick();
    chk("t4_level_pop", int'(level), 3);
    chk("t4_ready_high", int'(push_ready), 1);
    drain("t4");

    // timeout with flush of the rest of the chain
    do_reset();
    push(0, 0, 6, 1);
    push(0, 0, 6, 2);
    push(0, 1, 6, 3);
    wait_en("t5");
    repeat (TMO - 1) tick();
    chk("t5_en_last", int'(hdr_en), 1);
    chk("t5_no_err_yet", int'(cmd_err), 0);
    tick();
    chk("t5_err", int'(cmd_err), 1);
    chk("t5_err_tid", int'(cmd_tid), 1);
    chk("t5_en_off", int'(hdr_en), 0);
    tick(); tick();
    chk("t5_idle", int'(busy), 0);
    chk("t5_empty", int'(level), 0);

    // reset during RUN
    do_reset();
    push(1, 1, 6, 4);
    push(0, 1, 5, 9);
    wait_en("t6");
    rst = 1; hdr_done = 1; tick(); rst = 0; hdr_done = 0;
    chk("t6_en", int'(hdr_en), 0);
    chk("t6_level", int'(level), 0);
    chk("t6_toc", int'(toc), 1);
    chk("t6_mode", int'(mode), 6);
    chk("t6_no_done", int'(cmd_done), 0);
    chk("t6_no_err", int'(cmd_err), 0);

    // randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      push_valid = ($urandom_range(0, 2) == 0);
      push_cp    = 1'($urandom_range(0, 1));
      push_toc   = ($urandom_range(0, 2) != 0);
      push_mode  = 3'($urandom_range(0, 7));
      push_tid   = 4'($urandom_range(0, 15));
      seg_done   = ($urandom_range(0, 7) == 0);
      hdr_done   = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; push_valid = 0; seg_done = 0; hdr_done = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hdr_cmd_sequencer.md
Name: hdr_cmd_sequencer

Overview:
- Command scheduler in front of the HDR engine.
- Buffers HDR command descriptors (CP, TOC, MODE, TID) from the regfile/host side in a small FIFO.
- Presents each descriptor to the HDR engine with the required setup time, then drives the engine enable.
- Chains restart (TOC=0) segments by presenting the next descriptor early, and reports per-command completion, timeout and TID.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of 2, ≥2).
- SETUP_CYC, 2, cycles the config is held stable before enable rises.
- TIMEOUT_CYC, 1000, max RUN cycles without a segment-done before abort.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset.
- i_push_valid  in  1  descriptor push request.
- o_push_ready  out  1  FIFO not full.
- i_push_cp  in  1  command present (1=CCC, 0=normal DDR).
- i_push_toc  in  1  term of completion (1=exit, 0=restart).
- i_push_mode  in  3  HDR mode (6=DDR).
- i_push_tid  in  4  transaction ID.
- i_seg_done  in  1  ccc_done | ddr_mode_done from the mode blocks.
- i_hdr_done  in  1  HDR engine done pulse.
- o_hdr_en  out  1  HDR engine enable.
- o_cp, o_toc  out  1 each  config presented to the engine.
- o_mode  out  3  config presented to the engine.
- o_tid  out  4  TID of the running segment.
- o_cmd_done  out  1  1-cycle pulse, command chain finished OK.
- o_cmd_err  out  1  1-cycle pulse, chain aborted by timeout.
- o_cmd_tid  out  4  TID qualified by o_cmd_done/o_cmd_err.
- o_busy  out  1  state != IDLE.
- o_fifo_level  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (i_sys_rst=1 at a clock edge):
  - FIFO pointers and level = 0; FSM to IDLE.
  - o_hdr_en, o_cmd_done, o_cmd_err = 0.
  - o_cp = 0, o_toc = 1, o_mode = 6, o_tid = 0, o_cmd_tid = 0.
  - Reset mid-RUN drops o_hdr_en on the next edge; no done/err pulse is issued.
- FIFO:
  - Push when i_push_valid & o_push_ready. o_push_ready = (level != DEPTH).
  - Pop only by the FSM. Simultaneous push and pop at level==DEPTH is refused (ready=0).
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, RUN, FLUSH.
- IDLE:
  - If level ≥ 1 and head.toc=1: pop head into the current registers, drive o_cp/o_toc/o_mode/o_tid, go to SETUP.
  - If head.toc=0, also require level ≥ 2, so the successor is already present; otherwise wait.
- SETUP:
  - Counter runs SETUP_CYC cycles with o_hdr_en=0 and outputs stable.
  - Then o_hdr_en ← 1, go to RUN, clear the timeout counter.
- RUN, current toc=0 (lookahead):
  - o_cp/o_toc/o_mode show the head (next) descriptor.
  - o_tid keeps the current TID.
  - On i_seg_done: pop head into current, o_tid ← new TID, clear the timeout counter, stay in RUN with o_hdr_en held 1.
  - If the new current has toc=0 and the FIFO is now empty: hold outputs, keep waiting. The engine stays in its mode; the timeout still counts.
- RUN, current toc=1:
  - Outputs show current.
  - On i_hdr_done: o_hdr_en ← 0, o_cmd_done pulse, o_cmd_tid ← current TID, go to IDLE.
  - i_seg_done without i_hdr_done is ignored.
- Timeout:
  - Counter increments each RUN cycle and resets on i_seg_done.
  - On reaching TIMEOUT_CYC: o_hdr_en ← 0, o_cmd_err pulse with current TID.
  - If current toc=0, go to FLUSH; else go to IDLE.
- FLUSH: pop entries one per cycle until an entry with toc=1 is popped (inclusive), then go to IDLE. If the FIFO is empty, wait.
- Simultaneous events:
  - i_seg_done in the same cycle as the timeout: seg_done wins, no error.
  - Push during a pop is allowed; o_fifo_level is unchanged.
- o_cmd_done and o_cmd_err are never both 1.
- Latency:
  - Push to o_hdr_en rising is SETUP_CYC+2 cycles from an empty IDLE: 1 cycle FIFO write, 1 cycle pop/load, SETUP_CYC cycles setup.
  - i_hdr_done to o_cmd_done is 1 cycle.

Test Plan:
- Single CCC exit: push {cp=1,toc=1,mode=6,tid=3}.
  - o_hdr_en rises 4 cycles after the push with o_cp=1.
  - Pulse i_hdr_done → next cycle o_cmd_done=1, o_cmd_tid=3, o_hdr_en=0, o_busy=0.
- Restart chain: push tid5{cp=1,toc=0} then tid6{cp=0,toc=1}.
  - During tid5 RUN: o_cp=0, o_toc=1, o_tid=5.
  - i_seg_done → o_tid=6, o_hdr_en stays 1.
  - i_hdr_done → o_cmd_done with o_cmd_tid=6.
- Lookahead guard: push only {toc=0,tid=1} → FSM stays IDLE, o_hdr_en=0. Push a second descriptor → issue starts.
- FIFO full: push 5 descriptors back to back with DEPTH=4 → 5th refused (o_push_ready=0), o_fifo_level=4. One pop → ready=1.
- Timeout flush: chain tid1{toc=0}, tid2{toc=0}, tid3{toc=1}, TIMEOUT_CYC=20, no seg_done.
  - Cycle 20 of RUN: o_cmd_err=1, o_cmd_tid=1.
  - tid2 and tid3 are popped; FIFO empty; IDLE.
- Reset mid-RUN: assert i_sys_rst for 1 cycle during RUN → o_hdr_en=0, o_fifo_level=0, o_toc=1, o_mode=6, no pulses.
